// File: rtl/pcpi_div_arbiter.sv
// Round-robin arbiter sharing one PCPI divider among NREQ requesters.
// One operation in flight; results return tagged with the requester index.
module pcpi_div_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = $clog2(NREQ),
  parameter int unsigned CLAIM_TO = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_insn,
  input  logic [NREQ*32-1:0]   req_rs1,
  input  logic [NREQ*32-1:0]   req_rs2,
  output logic [NREQ-1:0]      req_ack,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 div_resetn,
  output logic                 pcpi_valid,
  output logic [31:0]          pcpi_insn,
  output logic [31:0]          pcpi_rs1,
  output logic [31:0]          pcpi_rs2,
  input  logic                 pcpi_wr,
  input  logic [31:0]          pcpi_rd,
  input  logic                 pcpi_wait,
  input  logic                 pcpi_ready
);

  localparam int unsigned CW = $clog2(CLAIM_TO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  claim_cnt_q, claim_cnt_d;
  logic           claimed_q, claimed_d;
  logic           pcpi_valid_q, pcpi_valid_d;
  logic [31:0]    pcpi_insn_q, pcpi_insn_d;
  logic [31:0]    pcpi_rs1_q, pcpi_rs1_d;
  logic [31:0]    pcpi_rs2_q, pcpi_rs2_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [31:0]    slot_insn [NREQ];
  logic [31:0]    slot_rs1  [NREQ];
  logic [31:0]    slot_rs2  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign slot_insn[gi] = req_insn[32*gi +: 32];
    assign slot_rs1[gi]  = req_rs1[32*gi +: 32];
    assign slot_rs2[gi]  = req_rs2[32*gi +: 32];
  end

  // First valid request scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ack = '0;
    if (state_q == IDLE && gnt_any && !reset) req_ack[gnt_id] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    claim_cnt_d  = claim_cnt_q;
    claimed_d    = claimed_q;
    pcpi_valid_d = pcpi_valid_q;
    pcpi_insn_d  = pcpi_insn_q;
    pcpi_rs1_d   = pcpi_rs1_q;
    pcpi_rs2_d   = pcpi_rs2_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = '0;
    rsp_data_d   = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          id_d         = gnt_id;
          pcpi_insn_d  = slot_insn[gnt_id];
          pcpi_rs1_d   = slot_rs1[gnt_id];
          pcpi_rs2_d   = slot_rs2[gnt_id];
          pcpi_valid_d = 1'b1;
          claim_cnt_d  = '0;
          claimed_d    = 1'b0;
          rr_ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Claim counter freezes once the divider has raised pcpi_wait.
        if (pcpi_wait) begin
          claimed_d = 1'b1;
        end else if (!claimed_q && claim_cnt_q != CW'(CLAIM_TO)) begin
          claim_cnt_d = claim_cnt_q + CW'(1);
        end
        if (pcpi_ready) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_data_d   = pcpi_wr ? pcpi_rd : 32'd0;
          pcpi_valid_d = 1'b0;
          state_d      = GAP;
        end else if (!claimed_q && !pcpi_wait && claim_cnt_q == CW'(CLAIM_TO)) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_err_d    = 1'b1;
          pcpi_valid_d = 1'b0;
          state_d      = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pcpi_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      claim_cnt_q  <= '0;
      claimed_q    <= 1'b0;
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= '0;
      pcpi_rs1_q   <= '0;
      pcpi_rs2_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      claim_cnt_q  <= claim_cnt_d;
      claimed_q    <= claimed_d;
      pcpi_valid_q <= pcpi_valid_d;
      pcpi_insn_q  <= pcpi_insn_d;
      pcpi_rs1_q   <= pcpi_rs1_d;
      pcpi_rs2_q   <= pcpi_rs2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign div_resetn = ~reset;
  assign pcpi_valid = pcpi_valid_q;
  assign pcpi_insn  = pcpi_insn_q;
  assign pcpi_rs1   = pcpi_rs1_q;
  assign pcpi_rs2   = pcpi_rs2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule
